// File: rtl/jt1942_obj_pkg.sv
// Shared constants and types for the object line buffer.
package jt1942_obj_pkg;
  localparam int OBJ_PXLW    = 4;
  localparam int OBJ_XW      = 9;
  localparam int OBJ_LBUF_AW = 8;
  localparam logic [OBJ_PXLW-1:0] OBJ_TRANSP = 4'hf;

  typedef logic [OBJ_PXLW-1:0]    obj_pxl_t;
  typedef logic [OBJ_LBUF_AW-1:0] obj_addr_t;

  function automatic logic obj_opaque(input obj_pxl_t p);
    return p != OBJ_TRANSP;
  endfunction
endpackage

// File: rtl/jt1942_obj_lbank.sv
// One 256x4 line-buffer bank: synchronous read port with enable, one write port.
// A read and a write to the same address in one cycle return the old content.
module jt1942_obj_lbank
  import jt1942_obj_pkg::*;
(
  input  logic      clk,
  input  logic      re,
  input  obj_addr_t raddr,
  output obj_pxl_t  rdata,
  input  logic      we,
  input  obj_addr_t waddr,
  input  obj_pxl_t  wdata
);
  obj_pxl_t mem [0:(1<<OBJ_LBUF_AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/jt1942_obj_linebuf.sv
// Ping-pong object line buffer: bank wsel collects drawn pixels, bank ~wsel is read and cleared.
// Optional macro JT1942_OBJ_FIRSTWIN_EN: keep the first opaque pixel drawn at an address.
module jt1942_obj_linebuf
  import jt1942_obj_pkg::*;
#(
  parameter logic [8:0] HSWAP = 9'd0,
  parameter int         CLRW  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen6,
  input  logic       flip,
  input  logic [8:0] H,
  input  logic [8:0] posx,
  input  logic [3:0] new_pxl,
  output logic [3:0] obj_pxl,
  output logic       clr_busy
);
  logic            wsel;
  logic [CLRW-1:0] clr_cnt;
  obj_addr_t       clr_addr;
  obj_addr_t       rd_addr;

  logic            s1_vld;
  logic [8:0]      s1_posx;
  obj_pxl_t        s1_pxl;
  logic            s1_bank;
  logic            rd_ok;
  logic            rd_bank;

  logic            s2_allow;
  logic            s2_we;
  logic            rc_we;

  logic [1:0]      bk_re;
  logic [1:0]      bk_we;
  obj_addr_t       bk_raddr [2];
  obj_addr_t       bk_waddr [2];
  obj_pxl_t        bk_wdata [2];
  obj_pxl_t        bk_rdata [2];

  assign clr_addr = OBJ_LBUF_AW'(clr_cnt);
  assign rd_addr  = H[7:0] ^ {OBJ_LBUF_AW{flip}};

`ifdef JT1942_OBJ_FIRSTWIN_EN
  logic     fwd_hit;
  obj_pxl_t fwd_pxl;
  obj_pxl_t s2_cur;

  // Remember a stage-2 write that the stage-1 RAM read could not yet see.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit <= 1'b0;
      fwd_pxl <= OBJ_TRANSP;
    end else if (cen6) begin
      fwd_hit <= s2_we && (s1_posx[7:0] == posx[7:0]) && (s1_bank == wsel);
      fwd_pxl <= s1_pxl;
    end else begin
      fwd_hit <= fwd_hit;
      fwd_pxl <= fwd_pxl;
    end
  end

  always_comb begin
    s2_cur   = fwd_hit ? fwd_pxl : bk_rdata[s1_bank];
    s2_allow = (s2_cur == OBJ_TRANSP);
  end
`else
  assign s2_allow = 1'b1;
`endif

  assign s2_we = !rst && !clr_busy && cen6 && s1_vld && !s1_posx[8]
                 && obj_opaque(s1_pxl) && s2_allow;
  assign rc_we = !rst && !clr_busy && cen6 && !H[8];

  // Bank port steering; a pending draw write beats the readout clear if they meet.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_re[b]    = cen6;
      bk_raddr[b] = (wsel == 1'(b)) ? posx[7:0] : rd_addr;
      bk_we[b]    = 1'b0;
      bk_waddr[b] = rd_addr;
      bk_wdata[b] = OBJ_TRANSP;
      if (clr_busy) begin
        bk_we[b]    = !rst;
        bk_waddr[b] = clr_addr;
      end else if (s2_we && (s1_bank == 1'(b))) begin
        bk_we[b]    = 1'b1;
        bk_waddr[b] = s1_posx[7:0];
        bk_wdata[b] = s1_pxl;
      end else if (rc_we && (wsel != 1'(b))) begin
        bk_we[b]    = 1'b1;
      end else begin
        bk_we[b]    = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jt1942_obj_lbank u_bank (
      .clk   (clk),
      .re    (bk_re[g]),
      .raddr (bk_raddr[g]),
      .rdata (bk_rdata[g]),
      .we    (bk_we[g]),
      .waddr (bk_waddr[g]),
      .wdata (bk_wdata[g])
    );
  end

  // Clear sweep, bank swap, draw stage 1 and readout bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel     <= 1'b0;
      clr_busy <= 1'b1;
      clr_cnt  <= '0;
      s1_vld   <= 1'b0;
      s1_posx  <= 9'h100;
      s1_pxl   <= OBJ_TRANSP;
      s1_bank  <= 1'b0;
      rd_ok    <= 1'b0;
      rd_bank  <= 1'b0;
    end else begin
      if (clr_busy) begin
        clr_cnt <= clr_cnt + CLRW'(1);
        if (clr_cnt == {CLRW{1'b1}}) clr_busy <= 1'b0;
      end
      if (cen6 && (H == HSWAP)) wsel <= ~wsel;
      if (clr_busy) begin
        s1_vld <= 1'b0;
        rd_ok  <= 1'b0;
      end else if (cen6) begin
        s1_vld  <= 1'b1;
        s1_posx <= posx;
        s1_pxl  <= new_pxl;
        s1_bank <= wsel;
        rd_ok   <= !H[8];
        rd_bank <= ~wsel;
      end
    end
  end

  always_comb begin
    obj_pxl = OBJ_TRANSP;
    if (rd_ok) obj_pxl = bk_rdata[rd_bank];
  end
endmodule
